wr_full_ctrl: RTL and testbench

//  Write-side pointer/full controller of the async FIFO, one clock (wr_clk). Owns the binary and

---
 rtl/wr_full_ctrl.sv | 95 +++++++++
 tb/tb_wr_full_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/wr_full_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wr_full_ctrl
//  Description : Write-side pointer, full/almost-full, fill level and sticky
//                overflow controller for an asynchronous FIFO (wr_clk domain).
//  Revision    : 1.0 - initial release
// ============================================================================
module wr_full_ctrl #(
    parameter int ADDR_SIZE    = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst,
    input  logic                 wr_inc,
    input  logic                 wr_ovf_clr,
    input  logic [ADDR_SIZE:0]   rd_ptr,
    output logic [ADDR_SIZE:0]   wr_ptr,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic                 wr_en,
    output logic                 wr_full,
    output logic                 wr_afull,
    output logic [ADDR_SIZE:0]   wr_count,
    output logic                 wr_ovf
);

    localparam logic [ADDR_SIZE:0] AFULL_LVL = (ADDR_SIZE + 1)'(AFULL_THRESH);

    logic [ADDR_SIZE:0] wr_bin_q,   wr_bin_d;
    logic [ADDR_SIZE:0] wr_ptr_q,   wr_ptr_d;
    logic [ADDR_SIZE:0] rd_sync1_q, rd_sync2_q;
    logic [ADDR_SIZE:0] wr_count_q, wr_count_d;
    logic               wr_full_q,  wr_full_d;
    logic               wr_afull_q, wr_afull_d;
    logic               wr_ovf_q,   wr_ovf_d;
    logic [ADDR_SIZE:0] rd_bin_s;
    logic               inc_ok;

    always_comb begin
        inc_ok   = wr_inc & ~wr_full_q;
        wr_bin_d = wr_bin_q + {{ADDR_SIZE{1'b0}}, inc_ok};
        wr_ptr_d = (wr_bin_d >> 1) ^ wr_bin_d;

        // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
        rd_bin_s = '0;
        for (int i = 0; i <= ADDR_SIZE; i++) begin
            rd_bin_s[i] = ^(rd_sync2_q >> i);
        end

        wr_count_d = wr_bin_d - rd_bin_s;
        wr_afull_d = (wr_count_d >= AFULL_LVL);
        wr_full_d  = (wr_ptr_d == {~rd_sync2_q[ADDR_SIZE:ADDR_SIZE-1],
                                    rd_sync2_q[ADDR_SIZE-2:0]});

        // A rejected write sets the flag even when a clear arrives on the same edge
        wr_ovf_d = wr_ovf_q;
        if (wr_inc && wr_full_q) begin
            wr_ovf_d = 1'b1;
        end else if (wr_ovf_clr) begin
            wr_ovf_d = 1'b0;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            wr_bin_q   <= '0;
            wr_ptr_q   <= '0;
            rd_sync1_q <= '0;
            rd_sync2_q <= '0;
            wr_count_q <= '0;
            wr_full_q  <= 1'b0;
            wr_afull_q <= 1'b0;
            wr_ovf_q   <= 1'b0;
        end else begin
            wr_bin_q   <= wr_bin_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_sync1_q <= rd_ptr;
            rd_sync2_q <= rd_sync1_q;
            wr_count_q <= wr_count_d;
            wr_full_q  <= wr_full_d;
            wr_afull_q <= wr_afull_d;
            wr_ovf_q   <= wr_ovf_d;
        end
    end

    // Memory writes are suppressed while reset is held
    assign wr_en    = wr_inc & ~wr_full_q & ~wr_rst;
    assign wr_ptr   = wr_ptr_q;
    assign wr_addr  = wr_bin_q[ADDR_SIZE-1:0];
    assign wr_full  = wr_full_q;
    assign wr_afull = wr_afull_q;
    assign wr_count = wr_count_q;
    assign wr_ovf   = wr_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_wr_full_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wr_full_ctrl
//  Description : Directed self-checking bench for wr_full_ctrl (ADDR_SIZE=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wr_full_ctrl;

    logic       wr_clk = 1'b0;
    logic       wr_rst;
    logic       wr_inc;
    logic       wr_ovf_clr;
    logic [4:0] rd_ptr;
    logic [4:0] wr_ptr;
    logic [3:0] wr_addr;
    logic       wr_en;
    logic       wr_full;
    logic       wr_afull;
    logic [4:0] wr_count;
    logic       wr_ovf;

    int errors = 0;
    int checks = 0;

    wr_full_ctrl #(.ADDR_SIZE(4), .AFULL_THRESH(12)) dut (
        .wr_clk    (wr_clk),
        .wr_rst    (wr_rst),
        .wr_inc    (wr_inc),
        .wr_ovf_clr(wr_ovf_clr),
        .rd_ptr    (rd_ptr),
        .wr_ptr    (wr_ptr),
        .wr_addr   (wr_addr),
        .wr_en     (wr_en),
        .wr_full   (wr_full),
        .wr_afull  (wr_afull),
        .wr_count  (wr_count),
        .wr_ovf    (wr_ovf)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    initial begin
        wr_rst = 1'b1; wr_inc = 1'b1; wr_ovf_clr = 1'b0; rd_ptr = 5'h1F;

        // Reset held two edges with hostile inputs
        tick(); #1;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        tick(); #1;
        check("rst_wr_ptr",   32'(wr_ptr),   32'd0);
        check("rst_wr_addr",  32'(wr_addr),  32'd0);
        check("rst_wr_full",  32'(wr_full),  32'd0);
        check("rst_wr_afull", 32'(wr_afull), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_wr_ovf",   32'(wr_ovf),   32'd0);
        check("rst_wr_en2",   32'(wr_en),    32'd0);

        // Fill 16 slots back to back
        wr_rst = 1'b0; rd_ptr = 5'd0; #1;
        check("rel_wr_en", 32'(wr_en), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            check($sformatf("fill_addr_%0d", k), 32'(wr_addr), 32'(k - 1));
            tick();
            check($sformatf("fill_count_%0d", k), 32'(wr_count), 32'(k));
            check($sformatf("fill_afull_%0d", k), 32'(wr_afull), 32'(k >= 12));
            check($sformatf("fill_full_%0d", k),  32'(wr_full),  32'(k == 16));
        end

        // Overflow while full, set-wins-over-clear, then clear alone
        #1;
        check("ovf_wr_en", 32'(wr_en), 32'd0);
        tick();
        check("ovf_wr_ptr",   32'(wr_ptr),   32'b11000);
        check("ovf_set",      32'(wr_ovf),   32'd1);
        check("ovf_count",    32'(wr_count), 32'd16);
        wr_ovf_clr = 1'b1;
        tick();
        check("ovf_set_wins", 32'(wr_ovf), 32'd1);
        wr_inc = 1'b0;
        tick();
        check("ovf_cleared",  32'(wr_ovf), 32'd0);
        check("ovf_ptr_hold", 32'(wr_ptr), 32'b11000);
        wr_ovf_clr = 1'b0;

        // Read advance reaches the flags on the third edge
        rd_ptr = 5'b00001;
        tick();
        check("lat_e1_full", 32'(wr_full), 32'd1);
        tick();
        check("lat_e2_full",  32'(wr_full),  32'd1);
        check("lat_e2_count", 32'(wr_count), 32'd16);
        tick();
        check("lat_e3_full",  32'(wr_full),  32'd0);
        check("lat_e3_count", 32'(wr_count), 32'd15);
        check("lat_e3_afull", 32'(wr_afull), 32'd1);

        // Reader catches up to gray 16, then 16 more writes wrap the pointer
        rd_ptr = 5'b11000;
        tick(); tick(); tick();
        check("wrap_empty_count", 32'(wr_count), 32'd0);
        check("wrap_empty_afull", 32'(wr_afull), 32'd0);
        wr_inc = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            check($sformatf("wrap_addr_%0d", k), 32'(wr_addr), 32'(k - 1));
            tick();
        end
        check("wrap_full",  32'(wr_full),  32'd1);
        check("wrap_ptr",   32'(wr_ptr),   32'd0);
        check("wrap_count", 32'(wr_count), 32'd16);

        // Drain, write 7, then reset mid-operation
        wr_inc = 1'b0; rd_ptr = 5'b00000;
        tick(); tick(); tick();
        check("drain_count", 32'(wr_count), 32'd0);
        wr_inc = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        check("mid_count", 32'(wr_count), 32'd7);
        check("mid_ptr",   32'(wr_ptr),   32'b00100);
        rd_ptr = 5'b00110;
        wr_rst = 1'b1;
        tick();
        check("mrst_count", 32'(wr_count), 32'd0);
        check("mrst_ptr",   32'(wr_ptr),   32'd0);
        check("mrst_full",  32'(wr_full),  32'd0);
        wr_rst = 1'b0; rd_ptr = 5'b00000; #1;
        check("mrst_addr",  32'(wr_addr), 32'd0);
        check("mrst_wr_en", 32'(wr_en),   32'd1);
        tick();
        check("mrst_count1", 32'(wr_count), 32'd1);
        check("mrst_addr1",  32'(wr_addr),  32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
